// File: rtl/sgm_pkg.sv
// Shared definitions for the SGM frame controller: FSM encoding and default
// half-image geometry.
package sgm_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    WAIT_DE = 2'd1,
    LINE    = 2'd2,
    HBLANK  = 2'd3
  } fsm_state_e;

  localparam int HALF_IMG_W_DEF      = 200;
  localparam int V_ACTIVE_DEF        = 64;
  localparam int DISPARITY_RANGE_DEF = 8;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for timing strobes, used to realign sync
// signals with a pipelined datapath.
module sync_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift chain; stage 0 captures the input, the last stage drives the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sgm_frame_ctrl.sv
// Frame timing controller for the SGM stereo core: tracks pixel coordinates,
// checks frame geometry and delays sync strobes to the datapath output.
module sgm_frame_ctrl
  import sgm_pkg::*;
#(
  parameter int HALF_IMG_W      = HALF_IMG_W_DEF,
  parameter int V_ACTIVE        = V_ACTIVE_DEF,
  parameter int DISPARITY_RANGE = DISPARITY_RANGE_DEF,
  parameter int PIPE_LATENCY    = 4,
  parameter int CNT_W           = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de_in,
  input  logic             h_sync_in,
  input  logic             v_sync_in,
  output logic             de_out,
  output logic             h_sync_out,
  output logic             v_sync_out,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             line_start,
  output logic             frame_start,
  output logic             border_mask,
  output logic             frame_done,
  output logic             locked,
  output logic             size_err
);

  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LINE_LEN  = CNT_W'(HALF_IMG_W);
  localparam logic [CNT_W-1:0] LAST_LINE = CNT_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] BORDER    = CNT_W'(DISPARITY_RANGE);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    else              return v + CNT_W'(1);
  endfunction

  fsm_state_e       state_q;
  logic [CNT_W-1:0] x_q, y_q;
  logic             de_q, vs_q;
  logic             frame_err_q, frame_done_q, locked_q, size_err_q;
  logic             vs_rise, de_fall;
  logic [2:0]       sync_q;

  assign vs_rise = v_sync_in & ~vs_q;
  assign de_fall = de_q & ~de_in;

  // Frame FSM; x_q holds the coordinate of the next pixel expected in LINE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SEARCH;
      x_q          <= '0;
      y_q          <= '0;
      de_q         <= 1'b0;
      vs_q         <= 1'b0;
      frame_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      locked_q     <= 1'b0;
      size_err_q   <= 1'b0;
    end else begin
      de_q         <= de_in;
      vs_q         <= v_sync_in;
      frame_done_q <= 1'b0;
      case (state_q)
        SEARCH: begin
          if (vs_rise) state_q <= WAIT_DE;
        end
        WAIT_DE: begin
          if (de_in) begin
            state_q     <= LINE;
            x_q         <= CNT_W'(1);
            y_q         <= '0;
            frame_err_q <= 1'b0;
          end
        end
        LINE: begin
          if (vs_rise) begin
            size_err_q <= 1'b1;
            locked_q   <= 1'b0;
            state_q    <= WAIT_DE;
          end else if (de_fall) begin
            if (x_q != LINE_LEN) begin
              size_err_q  <= 1'b1;
              locked_q    <= 1'b0;
              frame_err_q <= 1'b1;
            end
            state_q <= HBLANK;
          end else if (de_in) begin
            x_q <= sat_inc(x_q);
          end
        end
        HBLANK: begin
          if (vs_rise) begin
            if ((y_q == LAST_LINE) && !frame_err_q) begin
              frame_done_q <= 1'b1;
              locked_q     <= 1'b1;
            end else begin
              size_err_q <= 1'b1;
              locked_q   <= 1'b0;
            end
            state_q <= WAIT_DE;
          end else if (de_in) begin
            y_q     <= sat_inc(y_q);
            x_q     <= CNT_W'(1);
            state_q <= LINE;
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  // Zero-latency coordinates and strobes for the pixel currently on de_in.
  always_comb begin
    x_pos       = '0;
    y_pos       = '0;
    line_start  = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      WAIT_DE: begin
        line_start  = de_in;
        frame_start = de_in;
      end
      LINE: begin
        x_pos = x_q;
        y_pos = y_q;
      end
      HBLANK: begin
        y_pos      = de_in ? sat_inc(y_q) : y_q;
        line_start = de_in;
      end
      default: x_pos = '0;
    endcase
    if (de_in && (state_q != SEARCH) && (x_pos < BORDER)) border_mask = 1'b1;
    else                                                   border_mask = 1'b0;
  end

  sync_delay #(
    .DEPTH (PIPE_LATENCY),
    .WIDTH (3)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   ({de_in, h_sync_in, v_sync_in}),
    .q_o   (sync_q)
  );

  assign {de_out, h_sync_out, v_sync_out} = sync_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign size_err   = size_err_q;

endmodule

// File: tb/tb_sgm_frame_ctrl.sv
// Directed bench for sgm_frame_ctrl: 200x64 frames, geometry errors, border
// mask, sync delay and mid-frame reset.
module tb_sgm_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de_in = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0;
  logic        de_out, h_sync_out, v_sync_out;
  logic [11:0] x_pos, y_pos;
  logic        line_start, frame_start, border_mask, frame_done, locked, size_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;

  sgm_frame_ctrl #(
    .HALF_IMG_W(200), .V_ACTIVE(64), .DISPARITY_RANGE(8), .PIPE_LATENCY(4), .CNT_W(12)
  ) dut (
    .clk(clk), .rst_n(rst_n), .de_in(de_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .de_out(de_out), .h_sync_out(h_sync_out), .v_sync_out(v_sync_out),
    .x_pos(x_pos), .y_pos(y_pos), .line_start(line_start), .frame_start(frame_start),
    .border_mask(border_mask), .frame_done(frame_done), .locked(locked), .size_err(size_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic de, input logic hs, input logic vs);
    @(posedge clk); #1;
    de_in = de; h_sync_in = hs; v_sync_in = vs;
    #1;
    if (frame_done === 1'b1) done_cnt++;
  endtask

  task automatic vs_gap();
    cyc(1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_line(input int len, input int lidx, input bit chk);
    for (int p = 0; p < len; p++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (p == 0) begin
        total_cnt++;
        if (y_pos !== lidx[11:0]) $display("FAIL y_pos line %0d: got %0d want %0d", lidx, y_pos, lidx);
        else pass_cnt++;
        total_cnt++;
        if (frame_start !== (lidx == 0)) $display("FAIL frame_start line %0d: got %b want %b", lidx, frame_start, lidx == 0);
        else pass_cnt++;
      end
      if (chk) begin
        total_cnt++;
        if (x_pos !== p[11:0]) $display("FAIL x_pos pix %0d: got %0d want %0d", p, x_pos, p);
        else pass_cnt++;
        total_cnt++;
        if (border_mask !== (p < 8)) $display("FAIL border_mask pix %0d: got %b want %b", p, border_mask, p < 8);
        else pass_cnt++;
        total_cnt++;
        if (line_start !== (p == 0)) $display("FAIL line_start pix %0d: got %b want %b", p, line_start, p == 0);
        else pass_cnt++;
      end
    end
    cyc(1'b0, 1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_lines(input int from, input int to, input int chk_idx);
    for (int l = from; l < to; l++) send_line(200, l, l == chk_idx);
  endtask

  task automatic test_reset();
    de_in = 1'b1; v_sync_in = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    total_cnt++;
    if ({x_pos, y_pos} !== 24'd0) $display("FAIL reset_xy: got %0d/%0d want 0/0", x_pos, y_pos);
    else pass_cnt++;
    total_cnt++;
    if ({line_start, frame_start, border_mask, frame_done} !== 4'd0) $display("FAIL reset_pulses: got %b want 0000", {line_start, frame_start, border_mask, frame_done});
    else pass_cnt++;
    total_cnt++;
    if ({locked, size_err} !== 2'd0) $display("FAIL reset_status: got %b want 00", {locked, size_err});
    else pass_cnt++;
    total_cnt++;
    if ({de_out, h_sync_out, v_sync_out} !== 3'd0) $display("FAIL reset_delay: got %b want 000", {de_out, h_sync_out, v_sync_out});
    else pass_cnt++;
    de_in = 1'b0; v_sync_in = 1'b0;
    #1 rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_delay();
    logic obs;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i <= 6; i++) begin
        if (i == 0) cyc(k == 0, k == 1, k == 2);
        else        cyc(1'b0, 1'b0, 1'b0);
        obs = (k == 0) ? de_out : (k == 1) ? h_sync_out : v_sync_out;
        total_cnt++;
        if (obs !== (i == 4)) $display("FAIL delay sig %0d cycle %0d: got %b want %b", k, i, obs, i == 4);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_nominal();
    done_cnt = 0;
    vs_gap();
    send_lines(0, 64, 5);
    total_cnt++;
    if (locked !== 1'b0) $display("FAIL locked_before_f1: got %b want 0", locked);
    else pass_cnt++;
    vs_gap();
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL done_after_f1: got %0d want 1", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if (locked !== 1'b1) $display("FAIL locked_after_f1: got %b want 1", locked);
    else pass_cnt++;
    send_lines(0, 64, 20);
    vs_gap();
    send_lines(0, 64, 63);
    vs_gap();
    total_cnt++;
    if (done_cnt !== 3) $display("FAIL done_after_f3: got %0d want 3", done_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({locked, size_err} !== 2'b10) $display("FAIL status_after_f3: got %b want 10", {locked, size_err});
    else pass_cnt++;
  endtask

  task automatic test_short_line();
    int d0;
    send_lines(0, 10, -1);
    total_cnt++;
    if ({locked, size_err} !== 2'b10) $display("FAIL status_before_short: got %b want 10", {locked, size_err});
    else pass_cnt++;
    send_line(199, 10, 1'b0);
    total_cnt++;
    if ({locked, size_err} !== 2'b01) $display("FAIL status_after_short: got %b want 01", {locked, size_err});
    else pass_cnt++;
    send_lines(11, 64, -1);
    d0 = done_cnt;
    vs_gap();
    total_cnt++;
    if (done_cnt !== d0) $display("FAIL done_short_frame: got %0d want %0d", done_cnt, d0);
    else pass_cnt++;
    total_cnt++;
    if ({locked, size_err} !== 2'b01) $display("FAIL sticky_err: got %b want 01", {locked, size_err});
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    int d0;
    send_lines(0, 30, -1);
    for (int p = 0; p <= 100; p++) cyc(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (x_pos !== 12'd100) $display("FAIL x_before_reset: got %0d want 100", x_pos);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({x_pos, y_pos} !== 24'd0) $display("FAIL midreset_xy: got %0d/%0d want 0/0", x_pos, y_pos);
    else pass_cnt++;
    total_cnt++;
    if ({line_start, frame_start, border_mask, frame_done, locked, size_err} !== 6'd0)
      $display("FAIL midreset_flags: got %b want 000000", {line_start, frame_start, border_mask, frame_done, locked, size_err});
    else pass_cnt++;
    total_cnt++;
    if ({de_out, h_sync_out, v_sync_out} !== 3'd0) $display("FAIL midreset_delay: got %b want 000", {de_out, h_sync_out, v_sync_out});
    else pass_cnt++;
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int p = 0; p < 96; p++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (x_pos !== 12'd0 || line_start !== 1'b0 || frame_start !== 1'b0 || border_mask !== 1'b0) bad++;
    end
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 200; p++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (x_pos !== 12'd0 || line_start !== 1'b0 || frame_start !== 1'b0 || border_mask !== 1'b0) bad++;
    end
    repeat (5) cyc(1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (bad !== 0) $display("FAIL ignored_pixels: got %0d active cycles want 0", bad);
    else pass_cnt++;
    vs_gap();
    send_lines(0, 63, 3);
    total_cnt++;
    if (size_err !== 1'b0) $display("FAIL err_before_vs63: got %b want 0", size_err);
    else pass_cnt++;
    d0 = done_cnt;
    vs_gap();
    total_cnt++;
    if ({locked, size_err} !== 2'b01) $display("FAIL status_63_lines: got %b want 01", {locked, size_err});
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== d0) $display("FAIL done_63_lines: got %0d want %0d", done_cnt, d0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_delay();
    test_nominal();
    test_short_line();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
